// File: rtl/cache_types.sv
// Shared types for the cache write-back (victim) buffer.
package cache_types;

  localparam int unsigned PKG_ADDR_WIDTH  = 32;
  localparam int unsigned PKG_LINE_WIDTH  = 256;
  localparam int unsigned PKG_OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WB,
    RESP
  } wb_state_t;

  typedef logic [PKG_LINE_WIDTH-1:0] line_t;
  typedef logic [PKG_ADDR_WIDTH-1:0] addr_t;

  // Byte address -> line address: clears the in-line offset bits.
  function automatic addr_t line_addr(input addr_t addr, input int unsigned offset_bits);
    return addr & ~addr_t'((64'd1 << offset_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/wb_entry_reg.sv
// Single victim-buffer entry: valid flag, line address, line data and the
// hit comparator used for read forwarding.
module wb_entry_reg
  import cache_types::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  logic  clear_i,
  input  addr_t load_addr_i,
  input  line_t load_data_i,
  input  addr_t match_addr_i,
  output logic  valid_o,
  output addr_t addr_o,
  output line_t data_o,
  output logic  match_o
);

  logic  valid_q;
  addr_t addr_q;
  line_t data_q;

  // Valid flag and tag: a reset discards whatever line was held.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= load_addr_i;
    end
  end

  // Line payload; qualified by valid_q everywhere it is consumed.
  always_ff @(posedge clk) begin
    // NOTE: the wide data register is deliberately not reset; valid_q alone decides if it means anything.
    if (load_i) data_q <= load_data_i;
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  // Both sides carry zeroed offsets, so full equality is a line match.
  assign match_o = valid_q && (addr_q == match_addr_i);

endmodule

// File: rtl/cache_writeback_buffer.sv
// Write-back buffer between the cache's memory port and physical memory.
// Holds one evicted line so a fill can go first, forwards it to read hits,
// and drains it after an idle period or when a second eviction arrives.
module cache_writeback_buffer
  import cache_types::*;
#(
  parameter int unsigned ADDR_WIDTH  = PKG_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH  = PKG_LINE_WIDTH,
  parameter int unsigned OFFSET_BITS = PKG_OFFSET_BITS,
  parameter int unsigned DRAIN_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic                  phys_read,
  output logic                  phys_write,
  output logic [ADDR_WIDTH-1:0] phys_address,
  output logic [LINE_WIDTH-1:0] phys_wdata,
  input  logic [LINE_WIDTH-1:0] phys_rdata,
  input  logic                  phys_resp
);

  wb_state_t             state_q;
  logic [3:0]            idle_cnt_q;
  logic [LINE_WIDTH-1:0] pmem_rdata_q;
  logic                  pmem_resp_q;
  logic                  phys_read_q;
  logic                  phys_write_q;
  logic [ADDR_WIDTH-1:0] phys_address_q;
  logic [LINE_WIDTH-1:0] phys_wdata_q;

  logic  buf_valid;
  logic  buf_match;
  addr_t buf_addr;
  line_t buf_data;
  logic  buf_load;
  logic  buf_clear;
  addr_t req_line_addr;

  assign req_line_addr = line_addr(pmem_address, OFFSET_BITS);

  wb_entry_reg u_entry (
    .clk          (clk),
    .rst          (rst),
    .load_i       (buf_load),
    .clear_i      (buf_clear),
    .load_addr_i  (req_line_addr),
    .load_data_i  (pmem_wdata),
    .match_addr_i (req_line_addr),
    .valid_o      (buf_valid),
    .addr_o       (buf_addr),
    .data_o       (buf_data),
    .match_o      (buf_match)
  );

  // Entry load on an accepted eviction, clear when the drain completes.
  always_comb begin
    // NOTE: both strobes get a default before any condition, so no latch can be inferred.
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if (state_q == IDLE && pmem_write && !pmem_read && !buf_valid) buf_load = 1'b1;
    if (state_q == WB && phys_resp) buf_clear = 1'b1;
  end

  // Control FSM, idle counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idle_cnt_q     <= '0;
      pmem_rdata_q   <= '0;
      pmem_resp_q    <= 1'b0;
      phys_read_q    <= 1'b0;
      phys_write_q   <= 1'b0;
      phys_address_q <= '0;
      phys_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pmem_read && buf_match) begin
            pmem_rdata_q <= buf_data;
            pmem_resp_q  <= 1'b1;
            idle_cnt_q   <= '0;
            state_q      <= RESP;
          end else if (pmem_read) begin
            phys_read_q    <= 1'b1;
            phys_address_q <= req_line_addr;
            idle_cnt_q     <= '0;
            state_q        <= RD;
          end else if (pmem_write && !buf_valid) begin
            pmem_resp_q <= 1'b1;
            idle_cnt_q  <= '0;
            state_q     <= RESP;
          end else if (pmem_write ||
                       (buf_valid && idle_cnt_q == 4'(DRAIN_DELAY - 1))) begin
            // Forced drain (second eviction) or opportunistic drain.
            phys_write_q   <= 1'b1;
            phys_address_q <= buf_addr;
            phys_wdata_q   <= buf_data;
            idle_cnt_q     <= '0;
            state_q        <= WB;
          end else if (!buf_valid) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q != 4'hF) begin
            idle_cnt_q <= idle_cnt_q + 4'd1;
          end
        end
        RD: begin
          if (phys_resp) begin
            phys_read_q    <= 1'b0;
            phys_address_q <= '0;
            pmem_rdata_q   <= phys_rdata;
            pmem_resp_q    <= 1'b1;
            state_q        <= RESP;
          end
        end
        WB: begin
          if (phys_resp) begin
            phys_write_q   <= 1'b0;
            phys_address_q <= '0;
            phys_wdata_q   <= '0;
            state_q        <= IDLE;
          end
        end
        RESP: begin
          pmem_resp_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pmem_rdata   = pmem_rdata_q;
  assign pmem_resp    = pmem_resp_q;
  assign phys_read    = phys_read_q;
  assign phys_write   = phys_write_q;
  assign phys_address = phys_address_q;
  assign phys_wdata   = phys_wdata_q;

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Bench for cache_writeback_buffer: directed scenarios plus a randomized run
// checked against a flat "memory as seen by the cache" model.
`timescale 1ns/1ps
module tb_cache_writeback_buffer;

  typedef logic [255:0] line_t;
  typedef struct {
    bit        is_write;
    bit [31:0] addr;
    line_t     data;
  } phys_op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pmem_read = 1'b0;
  logic        pmem_write = 1'b0;
  logic [31:0] pmem_address = '0;
  line_t       pmem_wdata = '0;
  line_t       pmem_rdata;
  logic        pmem_resp;
  logic        phys_read;
  logic        phys_write;
  logic [31:0] phys_address;
  line_t       phys_wdata;
  line_t       phys_rdata;
  logic        phys_resp;

  int errors = 0;
  int checks = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  int phys_read_seen = 0;

  line_t    mem    [bit [31:0]];  // physical memory contents
  line_t    golden [bit [31:0]];  // what the cache should observe per line
  phys_op_t log_q  [$];           // completed physical transactions

  line_t d0, d1, r1;

  always #5 clk = ~clk;

  cache_writeback_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .phys_read    (phys_read),
    .phys_write   (phys_write),
    .phys_address (phys_address),
    .phys_wdata   (phys_wdata),
    .phys_rdata   (phys_rdata),
    .phys_resp    (phys_resp)
  );

  function automatic bit [31:0] line_of(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  function automatic line_t mem_default(input bit [31:0] la);
    return {8{la ^ 32'h5A5A_0000}};
  endfunction

  function automatic line_t mem_rd(input bit [31:0] la);
    return mem.exists(la) ? mem[la] : mem_default(la);
  endfunction

  function automatic line_t exp_rd(input logic [31:0] a);
    bit [31:0] la = line_of(a);
    return golden.exists(la) ? golden[la] : mem_default(la);
  endfunction

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Physical memory responder with programmable latency, plus bus monitor.
  initial begin
    phys_resp  = 1'b0;
    phys_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phys_resp = 1'b0;
        wait_cnt  = 0;
      end else begin
        checks++;
        if (phys_read && phys_write) begin
          errors++;
          $display("FAIL phys_exclusive: read=%b write=%b, required not both high", phys_read, phys_write);
        end
        if (phys_read || phys_write) begin
          checks++;
          if (phys_address[4:0] !== 5'd0) begin
            errors++;
            $display("FAIL phys_offset: address=%h, required offset bits 0", phys_address);
          end
        end
        if (phys_read) phys_read_seen++;
        if (phys_resp) begin
          phys_resp = 1'b0;
          wait_cnt  = 0;
        end else if (phys_read || phys_write) begin
          if (wait_cnt >= mem_lat) begin
            phys_resp = 1'b1;
            if (phys_write) begin
              mem[phys_address] = phys_wdata;
              log_q.push_back('{1'b1, phys_address, phys_wdata});
            end else begin
              phys_rdata = mem_rd(phys_address);
              log_q.push_back('{1'b0, phys_address, phys_rdata});
            end
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  task automatic apply_reset();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    golden = mem;
  endtask

  // Cache-side eviction; lat = edges until pmem_resp, -1 on timeout.
  task automatic do_write(input logic [31:0] a, input line_t d, output int lat);
    pmem_address = a;
    pmem_wdata   = d;
    pmem_write   = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (pmem_resp === 1'b1) begin lat = k; break; end
    end
    pmem_write = 1'b0;
    golden[line_of(a)] = d;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, output line_t d, output int lat);
    pmem_address = a;
    pmem_read    = 1'b1;
    lat = -1;
    d = '0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (pmem_resp === 1'b1) begin lat = k; d = pmem_rdata; break; end
    end
    pmem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (pmem_resp !== 1'b0) begin errors++; $display("FAIL reset_pmem_resp: got %b need 0", pmem_resp); end
    checks++; if (pmem_rdata !== '0) begin errors++; $display("FAIL reset_pmem_rdata: got %h need 0", pmem_rdata); end
    checks++; if (phys_read !== 1'b0) begin errors++; $display("FAIL reset_phys_read: got %b need 0", phys_read); end
    checks++; if (phys_write !== 1'b0) begin errors++; $display("FAIL reset_phys_write: got %b need 0", phys_write); end
    checks++; if (phys_address !== '0) begin errors++; $display("FAIL reset_phys_address: got %h need 0", phys_address); end
    checks++; if (phys_wdata !== '0) begin errors++; $display("FAIL reset_phys_wdata: got %h need 0", phys_wdata); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (phys_write !== 1'b0 || phys_read !== 1'b0) begin
      errors++; $display("FAIL reset_quiet: read=%b write=%b need 0/0", phys_read, phys_write);
    end
  endtask

  task automatic test_evict_empty();
    int lat;
    bit done;
    apply_reset();
    mem_lat = 1;
    do_write(32'h0000_1040, d0, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL evict_lat: got %0d need 1", lat); end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++; if (phys_write !== 1'b0 || phys_read !== 1'b0) begin
        errors++; $display("FAIL evict_early_drain: idle cycle %0d read=%b write=%b need 0/0", k, phys_read, phys_write);
      end
    end
    @(posedge clk); #1;
    checks++; if (phys_write !== 1'b1) begin errors++; $display("FAIL evict_drain_start: write=%b need 1", phys_write); end
    checks++; if (phys_address !== 32'h0000_1040) begin errors++; $display("FAIL evict_drain_addr: got %h need 00001040", phys_address); end
    checks++; if (phys_wdata !== d0) begin errors++; $display("FAIL evict_drain_data: got %h need %h", phys_wdata, d0); end
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk); #1;
      if (phys_write === 1'b0) done = 1'b1;
    end
    checks++; if (!done || mem_rd(32'h0000_1040) !== d0) begin
      errors++; $display("FAIL evict_mem: got %h need %h", mem_rd(32'h0000_1040), d0);
    end
  endtask

  task automatic test_read_before_drain();
    int lat;
    int n;
    line_t rd;
    apply_reset();
    mem[32'h0000_2000]    = r1;
    golden[32'h0000_2000] = r1;
    mem_lat = 2;
    do_write(32'h0000_1040, d0, lat);
    n = log_q.size();
    do_read(32'h0000_2000, rd, lat);
    checks++; if (lat != mem_lat + 2) begin errors++; $display("FAIL rbd_lat: got %0d need %0d", lat, mem_lat + 2); end
    checks++; if (rd !== r1) begin errors++; $display("FAIL rbd_data: got %h need %h", rd, r1); end
    checks++; if (log_q.size() != n + 1 || log_q[n].is_write || log_q[n].addr != 32'h0000_2000) begin
      errors++; $display("FAIL rbd_order: log size %0d need %0d with read of 00002000 first", log_q.size(), n + 1);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++; if (phys_write !== 1'b0) begin errors++; $display("FAIL rbd_early_drain: cycle %0d write=%b need 0", k, phys_write); end
    end
    @(posedge clk); #1;
    checks++; if (phys_write !== 1'b1 || phys_address !== 32'h0000_1040) begin
      errors++; $display("FAIL rbd_drain: write=%b addr=%h need 1 / 00001040", phys_write, phys_address);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_forward_and_full();
    int lat;
    int s;
    int n;
    line_t rd;
    apply_reset();
    mem_lat = 1;
    do_write(32'h0000_1040, d0, lat);
    s = phys_read_seen;
    do_read(32'h0000_105C, rd, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL fwd_lat: got %0d need 1", lat); end
    checks++; if (rd !== d0) begin errors++; $display("FAIL fwd_data: got %h need %h", rd, d0); end
    checks++; if (phys_read_seen != s) begin errors++; $display("FAIL fwd_no_phys_read: cycles %0d need 0", phys_read_seen - s); end
    mem_lat = 2;
    n = log_q.size();
    do_write(32'h0000_3000, d1, lat);
    checks++; if (lat != mem_lat + 3) begin errors++; $display("FAIL full_lat: got %0d need %0d", lat, mem_lat + 3); end
    checks++; if (log_q.size() != n + 1 || !log_q[n].is_write || log_q[n].addr != 32'h0000_1040 || log_q[n].data !== d0) begin
      errors++; $display("FAIL full_drain: log size %0d need %0d with write 00001040/D0", log_q.size(), n + 1);
    end
    do_read(32'h0000_3000, rd, lat);
    checks++; if (lat != 1 || rd !== d1) begin
      errors++; $display("FAIL full_holds_new: lat %0d data %h need 1 / %h", lat, rd, d1);
    end
  endtask

  task automatic test_read_mid_drain();
    int lat;
    int n;
    bit seen;
    line_t rd;
    apply_reset();
    mem_lat = 2;
    do_write(32'h0000_1040, d0, lat);
    n = log_q.size();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (phys_write === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_drain_start: write=%b need 1", phys_write); end
    do_read(32'h0000_1040, rd, lat);
    checks++; if (lat != 2 * mem_lat + 3) begin errors++; $display("FAIL mid_lat: got %0d need %0d", lat, 2 * mem_lat + 3); end
    checks++; if (rd !== d0) begin errors++; $display("FAIL mid_data: got %h need %h", rd, d0); end
    checks++; if (log_q.size() != n + 2 || !log_q[n].is_write || log_q[n+1].is_write || log_q[n+1].addr != 32'h0000_1040) begin
      errors++; $display("FAIL mid_order: log size %0d need %0d, write then read of 00001040", log_q.size(), n + 2);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    int n;
    bit seen;
    bit wrote;
    line_t rd;
    apply_reset();
    mem_lat = 10;
    do_write(32'h0000_1040, d0, lat);
    do_read(32'h0000_1040, rd, lat);
    checks++; if (rd !== d0) begin errors++; $display("FAIL ar_pre_hit: got %h need %h", rd, d0); end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (phys_write === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL ar_drain_start: write=%b need 1", phys_write); end
    #2 rst = 1'b1;
    #1;
    checks++; if (phys_write !== 1'b0 || phys_read !== 1'b0 || pmem_resp !== 1'b0) begin
      errors++; $display("FAIL ar_ctrl: write=%b read=%b resp=%b need 0", phys_write, phys_read, pmem_resp);
    end
    checks++; if (phys_address !== '0 || phys_wdata !== '0 || pmem_rdata !== '0) begin
      errors++; $display("FAIL ar_data: addr=%h wdata=%h rdata=%h need 0", phys_address, phys_wdata, pmem_rdata);
    end
    #13 rst = 1'b0;
    n = log_q.size();
    wrote = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (phys_write !== 1'b0) wrote = 1'b1;
    end
    checks++; if (wrote || log_q.size() != n) begin
      errors++; $display("FAIL ar_no_drain: write seen %b, ops %0d need 0", wrote, log_q.size() - n);
    end
    golden  = mem;
    mem_lat = 1;
    do_read(32'h0000_1040, rd, lat);
    checks++; if (lat != 3 || rd !== exp_rd(32'h0000_1040)) begin
      errors++; $display("FAIL ar_discarded: lat %0d data %h need 3 / %h", lat, rd, exp_rd(32'h0000_1040));
    end
  endtask

  task automatic test_random();
    bit [31:0] lines [6] = '{32'h0000_1040, 32'h0000_2000, 32'h0000_3000,
                             32'h0000_1060, 32'h8000_0020, 32'h0000_0000};
    int lat;
    logic [31:0] a;
    line_t rd;
    line_t ex;
    apply_reset();
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      mem_lat = $urandom_range(0, 3);
      a = lines[$urandom_range(0, 5)] | 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, rand_line(), lat);
        checks++; if (lat < 1) begin errors++; $display("FAIL rnd_write_timeout: txn %0d addr %h", t, a); end
      end else begin
        ex = exp_rd(a);
        do_read(a, rd, lat);
        checks++; if (lat < 1 || rd !== ex) begin
          errors++; $display("FAIL rnd_read: txn %0d addr %h lat %0d got %h need %h", t, a, lat, rd, ex);
        end
      end
    end
    repeat (30) @(posedge clk);
    #1;
    foreach (golden[k]) begin
      checks++; if (mem_rd(k) !== golden[k]) begin
        errors++; $display("FAIL rnd_flush: line %h got %h need %h", k, mem_rd(k), golden[k]);
      end
    end
  endtask

  initial begin
    d0 = rand_line();
    d1 = rand_line();
    r1 = rand_line();
    test_reset();
    test_evict_empty();
    test_read_before_drain();
    test_forward_and_full();
    test_read_mid_drain();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_writeback_buffer.md
Name: cache_writeback_buffer

Overview:
- Single-entry write-back (victim) buffer between the 2-way cache's physical-memory port and physical memory.
- Accepts a 256-bit dirty-line eviction from the cache in one cycle, so the following line fill can reach memory first.
- Forwards buffered data to cache read misses that hit the buffered line.
- Drains the buffer to memory when the port has been idle long enough, or when a second eviction forces it.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cache line width in bits.
- OFFSET_BITS, 5, line-offset bits ignored for address match; buffered address stored with offset forced to 0.
- DRAIN_DELAY, 4, consecutive idle cycles with a valid entry before an opportunistic drain starts; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pmem_read  in  1  line read request from cache; held until pmem_resp.
- pmem_write  in  1  line write (eviction) from cache; held until pmem_resp; never asserted together with pmem_read.
- pmem_address  in  ADDR_WIDTH  line address from cache.
- pmem_wdata  in  LINE_WIDTH  eviction data.
- pmem_rdata  out  LINE_WIDTH  read data, registered, valid while pmem_resp=1.
- pmem_resp  out  1  one-cycle completion pulse to cache.
- phys_read  out  1  read request to physical memory.
- phys_write  out  1  write request to physical memory.
- phys_address  out  ADDR_WIDTH  physical memory address.
- phys_wdata  out  LINE_WIDTH  physical memory write data.
- phys_rdata  in  LINE_WIDTH  physical memory read data.
- phys_resp  in  1  physical memory completion; the request drops in the following cycle.

Behaviour:
- Storage: buf_valid, buf_addr (offset zeroed), buf_data. Also idle_cnt, 4-bit saturating.
- Reset: state IDLE; buf_valid=0, idle_cnt=0; all outputs 0, including pmem_rdata. Reset mid-drain or mid-read aborts immediately and discards the buffered line (system-wide reset only).
- Address match: buf_valid && buf_addr[ADDR_WIDTH-1:OFFSET_BITS] == pmem_address[ADDR_WIDTH-1:OFFSET_BITS].
- FSM states: IDLE, RD, WB, RESP. All phys_* and pmem_resp are Moore outputs of state/registers.
- IDLE, priority order:
  1. pmem_read && match -> pmem_rdata<=buf_data, go RESP.
  2. pmem_read && !match -> go RD.
  3. pmem_write && !buf_valid -> capture address/data, buf_valid<=1, go RESP.
  4. pmem_write && buf_valid -> go WB (forced drain); the write is captured on return to IDLE.
  5. no request && buf_valid && idle_cnt==DRAIN_DELAY-1 -> go WB.
  6. otherwise stay.
- idle_cnt increments in IDLE while buf_valid and no request; clears on any request, on leaving IDLE, and when !buf_valid.
- RD: phys_read=1, phys_address=pmem_address with offset zeroed. On phys_resp: pmem_rdata<=phys_rdata, go RESP.
- WB: phys_write=1, phys_address=buf_addr, phys_wdata=buf_data; cannot be aborted by a cache read. On phys_resp: buf_valid<=0, go IDLE.
- RESP: pmem_resp=1 for exactly one cycle, then IDLE. The cache drops its request at that edge, so IDLE never re-sees a served request.
- Latency (request first seen in IDLE at cycle N):
  - write accept, or read hit in buffer: pmem_resp at N+1.
  - read miss: phys_read from N+1; phys_resp at cycle M gives pmem_resp at M+1.
  - write with full buffer: drain latency + 1 + 1.
- phys_read and phys_write are never high together; phys_* are 0 in IDLE and RESP.
- Coherence: a read to the buffered line always returns the buffer contents, never stale memory. A write to the same line as the buffered entry forces a drain, then overwrites the entry (no merge).

Decomposition:
- Shared package (cache_types): wb_state_t enum {IDLE, RD, WB, RESP}, line_t (LINE_WIDTH logic), line_addr() function that zeroes the offset.
- One sub-module: wb_entry_reg, holding valid/addr/data with load/clear controls and the match comparator output.
- FSM and idle counter stay in the top block.

Test Plan:
- Eviction into empty buffer: pmem_write, addr 0x0000_1040 (stored as 0x0000_1040), data D0 -> pmem_resp at N+1; no phys_* activity for the next 3 idle cycles; phys_write with address 0x0000_1040, data D0 starts after the 4th idle cycle.
- Read-before-drain: eviction 0x1040, then immediately pmem_read 0x2000 -> phys_read to 0x2000 first; memory returns R1; pmem_rdata=R1; the drain of 0x1040 follows after 4 idle cycles.
- Forwarding: buffer holds 0x1040/D0, pmem_read 0x105C -> pmem_resp at N+1 with pmem_rdata=D0; no phys_read issued.
- Full buffer: buffer holds 0x1040/D0, pmem_write 0x3000/D1 -> phys_write 0x1040/D0 first; after its phys_resp, D1 is captured and pmem_resp follows 2 cycles later; buffer holds 0x3000.
- Read arriving mid-drain: pmem_read 0x1040 during WB of 0x1040 -> phys_write completes, then phys_read 0x1040 is issued; pmem_rdata equals the memory model's post-write value D0.
- Async reset asserted mid-WB, not aligned to clk -> all outputs 0 immediately; after release, buf_valid=0 and no phys_write occurs without a new eviction.
